// File: rtl/sync_down_timer.sv
// Synchronous down-counting timer with one-shot and periodic auto-reload modes.
// Optional pause input is enabled by defining TIMER_PAUSE_EN.
module sync_down_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             periodic,
`ifdef TIMER_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             tc
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [WIDTH-1:0] q_r, q_s;
   logic [WIDTH-1:0] reload_r, reload_s;
   logic             mode_r, mode_s;
   logic             tc_r, tc_s;
   logic             busy_r;
   logic             hold_s;

`ifdef TIMER_PAUSE_EN
   assign hold_s = pause & (state_r == RUN);
`else
   assign hold_s = 1'b0;
`endif

   // Next-state and next-output decode; stop beats start, start beats pause.
   always_comb begin
      state_s  = state_r;
      q_s      = q_r;
      tc_s     = 1'b0;
      reload_s = reload_r;
      mode_s   = mode_r;
      if (stop) begin
         state_s = IDLE;
      end else if (start) begin
         if (load_val != ZERO) begin
            q_s      = load_val;
            reload_s = load_val;
            mode_s   = periodic;
            state_s  = RUN;
         end else begin
            q_s     = ZERO;
            tc_s    = 1'b1;
            state_s = IDLE;
         end
      end else if (hold_s) begin
         state_s = RUN;
      end else begin
         case (state_r)
            RUN: begin
               if (q_r > ONE) begin
                  q_s = q_r - ONE;
               end else if (q_r == ONE) begin
                  q_s     = ZERO;
                  tc_s    = 1'b1;
                  state_s = mode_r ? RUN : IDLE;
               end else begin
                  // Zero is only held in RUN for the extra reload cycle of periodic mode.
                  q_s = reload_r;
               end
            end
            IDLE: begin
               q_s = q_r;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         q_r      <= ZERO;
         reload_r <= ZERO;
         mode_r   <= 1'b0;
         tc_r     <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         q_r      <= q_s;
         reload_r <= reload_s;
         mode_r   <= mode_s;
         tc_r     <= tc_s;
         busy_r   <= (state_s == RUN);
      end
   end

   assign Q    = q_r;
   assign busy = busy_r;
   assign tc   = tc_r;

endmodule
